// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one iterative signed divider among NUM_REQ requesters
// Optional zero-divisor bypass: define DIV_ARB_ZERO_BYPASS_EN.
module div_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_quotient,
    output logic [DATA_WIDTH-1:0]           rsp_remainder,
    output logic                            rsp_error,
    output logic                            div_valid_in,
    output logic [DATA_WIDTH-1:0]           div_dividend,
    output logic [DATA_WIDTH-1:0]           div_divisor,
    input  logic [DATA_WIDTH-1:0]           div_quotient,
    input  logic [DATA_WIDTH-1:0]           div_remainder,
    input  logic                            div_valid_out,
    input  logic                            div_overflow
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_WAIT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BYPASS,
        S_RESP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        owner;
    logic [CNT_W-1:0]        wait_cnt;
    logic [DATA_WIDTH-1:0]   res_q;
    logic [DATA_WIDTH-1:0]   res_r;
    logic                    res_err;

    logic                    grant_found;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        cand;
    logic [DATA_WIDTH-1:0]   sel_dividend;
    logic [DATA_WIDTH-1:0]   sel_divisor;
    logic                    bypass_hit;
    logic                    timeout;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_dividend = req_dividend[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_divisor  = req_divisor[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign timeout      = (wait_cnt == CNT_W'(MAX_WAIT - 1));

`ifdef DIV_ARB_ZERO_BYPASS_EN
    assign bypass_hit = (sel_divisor == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        div_valid_in = 1'b0;
        rsp_valid    = '0;
        case (state_q)
            S_IDLE: begin
                // Gated by reset so nothing handshakes while the block is held in reset.
                if (grant_found && reset) begin
                    req_ready = NUM_REQ'(1) << grant_idx;
                    state_d   = bypass_hit ? S_BYPASS : S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_valid_in = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (div_valid_out || timeout) begin
                    state_d = S_RESP;
                end
            end
            S_BYPASS: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid[owner] = 1'b1;
                state_d          = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr       <= '0;
            owner        <= '0;
            wait_cnt     <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            res_q        <= '0;
            res_r        <= '0;
            res_err      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        owner        <= grant_idx;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        wait_cnt     <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                        // Saturate toward the dividend's sign; remainder is the dividend itself.
                        if (bypass_hit) begin
                            res_q   <= sel_dividend[DATA_WIDTH-1] ?
                                       {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                       {1'b0, {(DATA_WIDTH-1){1'b1}}};
                            res_r   <= sel_dividend;
                            res_err <= 1'b1;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                S_WAIT: begin
                    // Operands are left untouched: the divider resamples them on its last cycle.
                    wait_cnt <= wait_cnt + 1'b1;
                    if (div_valid_out) begin
                        res_q   <= div_quotient;
                        res_r   <= div_remainder;
                        res_err <= div_overflow;
                    end else if (timeout) begin
                        res_q   <= '0;
                        res_r   <= '0;
                        res_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_quotient  = res_q;
    assign rsp_remainder = res_r;
    assign rsp_error     = res_err;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed table-driven bench for div_arbiter with a behavioural divider model
module tb_div_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_dividend = '0;
    logic [NR*DW-1:0]  req_divisor = '0;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_quotient;
    logic [DW-1:0]     rsp_remainder;
    logic              rsp_error;
    logic              div_valid_in;
    logic [DW-1:0]     div_dividend;
    logic [DW-1:0]     div_divisor;
    logic [DW-1:0]     div_quotient = '0;
    logic [DW-1:0]     div_remainder = '0;
    logic              div_valid_out = 1'b0;
    logic              div_overflow = 1'b0;

    div_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_WAIT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder), .rsp_error(rsp_error),
        .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_valid_out(div_valid_out), .div_overflow(div_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_issue = 0;
    int n_ready = 0;
    int n_rsp = 0;
    int last_issue_cyc = 0;
    int stable_bad = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (div_valid_in) begin
            n_issue++;
            last_issue_cyc = cyc;
        end
        if (req_ready != 0) n_ready++;
        if (rsp_valid != 0) n_rsp++;
    end

    // Divider model: fixed latency, resamples operands on its final cycle.
    logic              model_en = 1'b1;
    logic              force_vo = 1'b0;
    int                mcnt = 0;
    logic              mbusy = 1'b0;
    logic [DW-1:0]     m_a0 = '0;
    logic [DW-1:0]     m_a_last = '0;
    logic signed [DW-1:0] sa, sb;

    always @(negedge clk) begin
        div_valid_out = 1'b0;
        div_overflow  = 1'b0;
        if (mbusy) begin
            mcnt--;
            if (mcnt == 0) begin
                mbusy    = 1'b0;
                sa       = div_dividend;
                sb       = div_divisor;
                m_a_last = div_dividend;
                if (sb == 0) begin
                    div_quotient = '1; div_remainder = sa; div_overflow = 1'b1;
                end else if (sa == 32'sh80000000 && sb == -1) begin
                    div_quotient = sa; div_remainder = '0; div_overflow = 1'b1;
                end else begin
                    div_quotient = sa / sb; div_remainder = sa % sb;
                end
                div_valid_out = 1'b1;
            end
        end
        if (div_valid_in && model_en) begin
            mbusy = 1'b1;
            mcnt  = 3;
            m_a0  = div_dividend;
        end
        if (force_vo) div_valid_out = 1'b1;
        if (mbusy && div_dividend !== m_a0) stable_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b,
                        output int acc_cyc, output logic [NR-1:0] gnt);
        @(posedge clk); #1;
        req_dividend[idx*DW +: DW] = a;
        req_divisor[idx*DW +: DW]  = b;
        req_valid[idx] = 1'b1;
        acc_cyc = -1;
        gnt = '0;
        for (int k = 0; k < 20 && acc_cyc < 0; k++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                acc_cyc = cyc;
                gnt = req_ready;
            end
        end
        if (acc_cyc < 0) fail_bound("accept");
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic get_rsp(output int ridx, output logic [31:0] q, output logic [31:0] r,
                           output logic e, output int rcyc);
        ridx = -1; q = '0; r = '0; e = 1'b0; rcyc = 0;
        for (int k = 0; k < 300 && ridx < 0; k++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                chk("rsp_onehot", $countones(rsp_valid), 1);
                for (int j = 0; j < NR; j++) if (rsp_valid[j]) ridx = j;
                q = rsp_quotient; r = rsp_remainder; e = rsp_error; rcyc = cyc;
            end
        end
        if (ridx < 0) fail_bound("response");
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t tv[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc, rc, ridx, i0, r0, s0;
        logic [NR-1:0] gnt;
        logic [31:0] q, r;
        logic e;

        tv[0] = '{0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0};
        tv[1] = '{2, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        tv[2] = '{1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        tv[3] = '{3, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1};
        tv[4] = '{1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};

        // Reset state, with every requester asking to be served.
        reset = 1'b0;
        req_valid = '1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_div_valid_in", div_valid_in, 0);
        chk("reset_div_dividend", div_dividend, 0);
        chk("reset_div_divisor", div_divisor, 0);
        chk("reset_rsp_quotient", rsp_quotient, 0);
        chk("reset_rsp_remainder", rsp_remainder, 0);
        chk("reset_rsp_error", rsp_error, 0);
        req_valid = '0;
        @(posedge clk); #1 reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            i0 = n_issue; r0 = n_ready; s0 = stable_bad;
            send(tv[i].idx, tv[i].a, tv[i].b, acc, gnt);
            get_rsp(ridx, q, r, e, rc);
            chk($sformatf("v%0d_grant", i), gnt, 32'd1 << tv[i].idx);
            chk($sformatf("v%0d_rsp_idx", i), ridx, tv[i].idx);
            chk($sformatf("v%0d_quotient", i), q, tv[i].q);
            chk($sformatf("v%0d_remainder", i), r, tv[i].r);
            chk($sformatf("v%0d_error", i), e, tv[i].e);
            chk($sformatf("v%0d_final_operand", i), m_a_last, tv[i].a);
            chk($sformatf("v%0d_issue_pulses", i), n_issue - i0, 1);
            chk($sformatf("v%0d_ready_cycles", i), n_ready - r0, 1);
            chk($sformatf("v%0d_operand_stable", i), stable_bad - s0, 0);
        end

        // Round-robin from rr_ptr = 0 with all requesters held high.
        pulse_reset();
        req_dividend = {32'd25, 32'd20, 32'd9, 32'd8};
        req_divisor  = {32'd5, 32'd4, 32'd3, 32'd2};
        req_valid = '1;
        begin
            int exp_idx[5] = '{0, 1, 2, 3, 0};
            logic [31:0] exp_q[5] = '{32'd4, 32'd3, 32'd5, 32'd5, 32'd4};
            for (int k = 0; k < 5; k++) begin
                get_rsp(ridx, q, r, e, rc);
                if (k == 4) req_valid = '0;
                chk($sformatf("rr%0d_idx", k), ridx, exp_idx[k]);
                chk($sformatf("rr%0d_quotient", k), q, exp_q[k]);
                chk($sformatf("rr%0d_error", k), e, 0);
            end
        end

        // Timeout: the divider never answers.
        model_en = 1'b0;
        send(1, 32'd50, 32'd5, acc, gnt);
        get_rsp(ridx, q, r, e, rc);
        chk("to_rsp_idx", ridx, 1);
        chk("to_latency", rc - last_issue_cyc, 64);
        chk("to_error", e, 1);
        chk("to_quotient", q, 0);
        chk("to_remainder", r, 0);
        model_en = 1'b1;
        send(1, 32'd9, 32'd3, acc, gnt);
        get_rsp(ridx, q, r, e, rc);
        chk("after_to_idx", ridx, 1);
        chk("after_to_quotient", q, 3);
        chk("after_to_error", e, 0);

        // Reset during WAIT, then a stray divider done pulse.
        model_en = 1'b0;
        i0 = n_issue;
        send(2, 32'd30, 32'd3, acc, gnt);
        repeat (3) @(posedge clk);
        r0 = n_rsp;
        pulse_reset();
        force_vo = 1'b1;
        @(posedge clk); #1 force_vo = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_wait_no_rsp", n_rsp - r0, 0);
        chk("rst_wait_issue", n_issue - i0, 1);
        chk("rst_wait_div_dividend", div_dividend, 0);
        chk("rst_wait_rsp_quotient", rsp_quotient, 0);
        model_en = 1'b1;
        @(posedge clk); #1;
        req_dividend = {32'd25, 32'd20, 32'd9, 32'd8};
        req_divisor  = {32'd5, 32'd4, 32'd3, 32'd2};
        req_valid = '1;
        @(negedge clk);
        chk("rst_wait_idle_grant0", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        get_rsp(ridx, q, r, e, rc);
        chk("rst_wait_next_idx", ridx, 0);
        chk("rst_wait_next_quotient", q, 4);

        // Zero divisor.
        i0 = n_issue;
        send(3, 32'hFFFFFFFB, 32'd0, acc, gnt);
        get_rsp(ridx, q, r, e, rc);
        chk("zero_idx", ridx, 3);
        chk("zero_remainder", r, 32'hFFFFFFFB);
        chk("zero_error", e, 1);
`ifdef DIV_ARB_ZERO_BYPASS_EN
        chk("zero_quotient", q, 32'h80000000);
        chk("zero_no_issue", n_issue - i0, 0);
        chk("zero_latency", rc - acc, 2);
        send(0, 32'd5, 32'd0, acc, gnt);
        get_rsp(ridx, q, r, e, rc);
        chk("zero_pos_quotient", q, 32'h7FFFFFFF);
        chk("zero_pos_remainder", r, 32'd5);
`else
        chk("zero_quotient", q, 32'hFFFFFFFF);
        chk("zero_issue", n_issue - i0, 1);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
